// File: rtl/predicting_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// predicting_fetch_unit_pkg
// Shared definitions for the predicting fetch stage:
//   - ctr_e      : 2-bit saturating branch counter encoding
//   - CTR_ALLOC  : counter value given to a freshly allocated BTB entry
//   - clog2()    : index-width helper for the BTB
//   - ctr_train(): one saturating step of a counter toward taken/not-taken
// -----------------------------------------------------------------------------
package predicting_fetch_unit_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,  // strong not-taken
    CTR_WNT = 2'b01,  // weak not-taken
    CTR_WT  = 2'b10,  // weak taken
    CTR_ST  = 2'b11   // strong taken
  } ctr_e;

  // A new entry starts weakly taken: one wrong outcome is enough to flip it.
  localparam ctr_e CTR_ALLOC = CTR_WT;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic ctr_e ctr_train(input ctr_e c, input logic taken);
    ctr_e r;
    r = c;
    if (taken) begin
      if (c != CTR_ST) r = ctr_e'(c + 2'd1);
    end else begin
      if (c != CTR_SNT) r = ctr_e'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/predicting_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// predicting_fetch_unit_if
// Bundles every non-clock/reset signal of the fetch stage.
//   imem side    : address_imem (out of fetch), q_imem (into fetch)
//   control      : stall, redirect_valid/redirect_pc (from execute)
//   BTB training : update_valid/pc/target/taken (from execute)
//   F/D latch    : fd_valid/pc/insn/pred_taken/pred_target (to decode)
// modport master = the fetch unit, modport slave = its environment.
// -----------------------------------------------------------------------------
interface predicting_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32
);

  logic [ADDR_W-1:0] address_imem;
  logic [INSN_W-1:0] q_imem;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              update_valid;
  logic [ADDR_W-1:0] update_pc;
  logic [ADDR_W-1:0] update_target;
  logic              update_taken;
  logic              fd_valid;
  logic [ADDR_W-1:0] fd_pc;
  logic [INSN_W-1:0] fd_insn;
  logic              fd_pred_taken;
  logic [ADDR_W-1:0] fd_pred_target;

  modport master (
    output address_imem,
    input  q_imem,
    input  stall,
    input  redirect_valid, redirect_pc,
    input  update_valid, update_pc, update_target, update_taken,
    output fd_valid, fd_pc, fd_insn, fd_pred_taken, fd_pred_target
  );

  modport slave (
    input  address_imem,
    output q_imem,
    output stall,
    output redirect_valid, redirect_pc,
    output update_valid, update_pc, update_target, update_taken,
    input  fd_valid, fd_pc, fd_insn, fd_pred_taken, fd_pred_target
  );

endinterface

// File: rtl/predicting_fetch_unit_btb_table.sv
// -----------------------------------------------------------------------------
// predicting_fetch_unit_btb_table
// Direct-mapped branch target buffer with 2-bit saturating counters.
//   clk, rst_n        : clock, async active-low reset (clears valid bits only)
//   lookup_pc         : PC being fetched (combinational read port)
//   pred_taken        : entry hits and its counter says taken
//   pred_target       : stored target of the indexed entry
//   update_*          : training port from execute, written at posedge
// A lookup and an update to the same index in one cycle: the lookup sees the
// old contents because the write only lands at the clock edge.
// -----------------------------------------------------------------------------
module predicting_fetch_unit_btb_table
  import predicting_fetch_unit_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_taken
);

  localparam int IDX_W = clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [BTB_DEPTH-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
  logic [ADDR_W-1:0]    target_q [BTB_DEPTH];
  ctr_e                 ctr_q    [BTB_DEPTH];

  // Read port
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;

  assign rd_idx      = lookup_pc[IDX_W-1:0];
  assign rd_tag      = lookup_pc[ADDR_W-1:IDX_W];
  assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign pred_taken  = rd_hit && (ctr_q[rd_idx] inside {CTR_WT, CTR_ST});
  assign pred_target = target_q[rd_idx];

  // Update port: one entry written per cycle at most
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;
  logic              wr_en;
  logic [TAG_W-1:0]  tag_d;
  logic [ADDR_W-1:0] target_d;
  ctr_e              ctr_d;

  assign upd_idx = update_pc[IDX_W-1:0];
  assign upd_tag = update_pc[ADDR_W-1:IDX_W];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_en    = 1'b0;
    tag_d    = upd_tag;
    target_d = update_target;
    ctr_d    = CTR_ALLOC;
    if (update_valid) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        ctr_d = ctr_train(ctr_q[upd_idx], update_taken);
        // A not-taken outcome says nothing about where the branch goes.
        if (!update_taken) target_d = target_q[upd_idx];
      end else if (update_taken) begin
        // Miss and taken: allocate, evicting whatever aliased there.
        wr_en = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else if (wr_en) valid_q[upd_idx] <= 1'b1;
  end

  // NOTE: tags, targets and counters are not reset; they are meaningless until
  // the valid bit is set, and leaving them resetless keeps this plain storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[upd_idx]    <= tag_d;
      target_q[upd_idx] <= target_d;
      ctr_q[upd_idx]    <= ctr_d;
    end
  end

endmodule

// File: rtl/predicting_fetch_unit.sv
// -----------------------------------------------------------------------------
// predicting_fetch_unit
// Fetch stage of the 5-stage core with BTB-based next-PC prediction.
//   clock : master clock, posedge
//   reset : asynchronous, active-low
//   bus   : predicting_fetch_unit_if.master (imem, stall, redirect, BTB
//           training, F/D latch outputs)
// Next-PC priority: redirect > stall > predicted next PC. A correct taken
// prediction steers the very next fetch without a bubble.
// -----------------------------------------------------------------------------
module predicting_fetch_unit
  import predicting_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                INSN_W    = 32,
  parameter int                BTB_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  predicting_fetch_unit_if.master bus
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] insn;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
  } fd_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  fd_t               fd_q, fd_d;

  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pred_next;

  predicting_fetch_unit_btb_table #(
    .ADDR_W   (ADDR_W),
    .BTB_DEPTH(BTB_DEPTH)
  ) u_btb (
    .clk          (clock),
    .rst_n        (reset),
    .lookup_pc    (pc_q),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .update_valid (bus.update_valid),
    .update_pc    (bus.update_pc),
    .update_target(bus.update_target),
    .update_taken (bus.update_taken)
  );

  // Wraps modulo 2^ADDR_W by construction.
  assign pc_plus1  = pc_q + ADDR_W'(1);
  assign pred_next = pred_taken ? pred_target : pc_plus1;

  always_comb begin
    pc_d = pc_q;
    fd_d = fd_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
      fd_d = '0;
    end else if (!bus.stall) begin
      pc_d             = pred_next;
      fd_d.valid       = 1'b1;
      fd_d.pc          = pc_q;
      fd_d.insn        = bus.q_imem;
      fd_d.pred_taken  = pred_taken;
      fd_d.pred_target = pred_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      fd_q <= '0;
    end else begin
      pc_q <= pc_d;
      fd_q <= fd_d;
    end
  end

  assign bus.address_imem   = pc_q;
  assign bus.fd_valid       = fd_q.valid;
  assign bus.fd_pc          = fd_q.pc;
  assign bus.fd_insn        = fd_q.insn;
  assign bus.fd_pred_taken  = fd_q.pred_taken;
  assign bus.fd_pred_target = fd_q.pred_target;

endmodule
